fetch_ctrl: RTL

//   Sequences the program counter register and the instruction-memory fetch port.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_ctrl_instr_buf.sv | 36 +++
 rtl/fetch_ctrl.sv | 71 +++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, DROP} fetch_state_t;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: PC register, instruction memory, decode and flush signals of the fetch stage.
interface fetch_ctrl_if;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  modport master (
    input  pc_cur, imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, trap_valid, trap_pc,
    output pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
  modport slave (
    output pc_cur, imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, trap_valid, trap_pc,
    input  pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_ctrl_instr_buf.sv
// instr_buf: single-entry valid/ready instruction holding register with flush.
module instr_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_o
);
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d, pc_q, pc_d;
  // a refill in the same cycle as an accept keeps the entry valid
  always_comb begin
    valid_d = flush_i ? 1'b0 : fill_i ? 1'b1 : (valid_q & ready_i) ? 1'b0 : valid_q;
    data_d  = fill_i ? data_i : data_q;
    pc_d    = fill_i ? pc_i : pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC selection and one-outstanding req/ack instruction fetch sequencing.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);
  fetch_state_t state_q, state_d;
  logic [31:0]  req_addr_q, req_addr_d, target;
  logic         flush, fill;
  assign flush  = bus.trap_valid | bus.redirect_valid;
  assign target = align_pc(bus.trap_valid ? bus.trap_pc : bus.redirect_pc);
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    bus.pc_next   = bus.pc_cur;
    bus.imem_req  = 1'b0;
    bus.imem_addr = req_addr_q;
    fill          = 1'b0;
    case (state_q)
      BOOT: state_d = ISSUE;
      ISSUE: begin
        if (!flush && (!bus.instr_valid || bus.instr_ready)) begin
          bus.imem_req  = 1'b1;
          bus.imem_addr = bus.pc_cur;
          req_addr_d    = bus.pc_cur;
          fill          = bus.imem_ack;
          state_d       = bus.imem_ack ? ISSUE : WAIT;
        end
      end
      WAIT: begin
        bus.imem_req = 1'b1;
        fill         = bus.imem_ack & ~flush;
        state_d      = bus.imem_ack ? ISSUE : flush ? DROP : WAIT;
      end
      DROP: begin
        bus.imem_req = 1'b1;
        state_d      = bus.imem_ack ? ISSUE : DROP;
      end
      default: state_d = BOOT;
    endcase
    // priority: reset over flush over a completed fetch over hold
    if (fill) bus.pc_next = bus.imem_addr + 32'(INSTR_BYTES);
    if (flush) bus.pc_next = target;
    if (!rst) bus.pc_next = RESET_PC;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end
  instr_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .fill_i  (fill),
    .flush_i (flush),
    .ready_i (bus.instr_ready),
    .data_i  (bus.imem_rdata),
    .pc_i    (bus.imem_addr),
    .valid_o (bus.instr_valid),
    .data_o  (bus.instr),
    .pc_o    (bus.instr_pc)
  );
endmodule
